imm_ext_unit: RTL and testbench

- Parametrised, registered successor to the opcode-based sign/zero-extension decision.
- Sits between the ID-stage field split and the ALU operand mux.
- Takes an opcode plus raw immediate, classifies the extension mode (zero, sign, upper), and produces a DATA_W-wide extended immediate.
- Output passes through a 2-entry skid buffer with valid/ready handshake, tag passthrough and pipeline flush, so ID can stall without losing decoded immediates.

---
 rtl/imm_ext_unit_if.sv | 32 +++
 rtl/imm_ext_unit.sv | 135 +++++++++++++
 tb/tb_imm_ext_unit.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/imm_ext_unit_if.sv
// Handshake bundle between the ID-stage field split (master) and the
// immediate extension unit (slave). Carries the input offer and the
// buffered, extended result back out toward the ALU operand mux.
interface imm_ext_unit_if #(
  parameter int IMM_W  = 16,
  parameter int DATA_W = 32,
  parameter int TAG_W  = 5
);

  logic              in_valid;
  logic              in_ready;
  logic [5:0]        in_opcode;
  logic [IMM_W-1:0]  in_imm;
  logic [TAG_W-1:0]  in_tag;

  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_imm;
  logic [1:0]        out_mode;
  logic [TAG_W-1:0]  out_tag;

  modport master (
    output in_valid, in_opcode, in_imm, in_tag, out_ready,
    input  in_ready, out_valid, out_imm, out_mode, out_tag
  );

  modport slave (
    input  in_valid, in_opcode, in_imm, in_tag, out_ready,
    output in_ready, out_valid, out_imm, out_mode, out_tag
  );

endinterface

// File: rtl/imm_ext_unit.sv
// Registered immediate extension unit. Decodes the extension mode from the
// opcode, widens the raw immediate to DATA_W bits and holds the result in a
// 2-entry skid buffer so ID can stall without losing decoded immediates.
// Optional feature: define IMM_EXT_UPPER_EN to decode opcode 0x0f as the
// upper (LUI) mode; otherwise 0x0f sign-extends and no shift path exists.
// DATA_W must be >= IMM_W.
module imm_ext_unit #(
  parameter int IMM_W  = 16,
  parameter int DATA_W = 32,
  parameter int TAG_W  = 5
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           flush,
  imm_ext_unit_if.slave  bus
);

  localparam int EXT_W = DATA_W - IMM_W;

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] TWO   = 2'd2;

  localparam logic [1:0] MODE_SIGN  = 2'd0;
  localparam logic [1:0] MODE_ZERO  = 2'd1;
`ifdef IMM_EXT_UPPER_EN
  localparam logic [1:0] MODE_UPPER = 2'd2;
`endif

  logic [1:0]        state;
  logic [1:0]        dec_mode;
  logic [DATA_W-1:0] ext_imm;
  logic              push;
  logic              pop;

  logic [DATA_W-1:0] head_imm;
  logic [1:0]        head_mode;
  logic [TAG_W-1:0]  head_tag;
  logic [DATA_W-1:0] tail_imm;
  logic [1:0]        tail_mode;
  logic [TAG_W-1:0]  tail_tag;

  // Classify the opcode: logical-immediate ops zero-fill, LUI optionally
  // goes to the upper path, everything else sign-extends.
  always_comb begin
    dec_mode = MODE_SIGN;
    case (bus.in_opcode)
      6'h0c, 6'h0d, 6'h0e, 6'h24, 6'h25: dec_mode = MODE_ZERO;
`ifdef IMM_EXT_UPPER_EN
      6'h0f: dec_mode = MODE_UPPER;
`endif
      default: dec_mode = MODE_SIGN;
    endcase
  end

  // When no widening is needed every mode degenerates to a plain pass of
  // the raw field; the wide branch avoids zero-width replications.
  generate
    if (EXT_W == 0) begin : g_same_width
      assign ext_imm = bus.in_imm;
    end else begin : g_wide
      // Build the widened immediate for the decoded mode.
      always_comb begin
        ext_imm = {{EXT_W{bus.in_imm[IMM_W-1]}}, bus.in_imm};
        if (dec_mode == MODE_ZERO) begin
          ext_imm = {{EXT_W{1'b0}}, bus.in_imm};
        end
`ifdef IMM_EXT_UPPER_EN
        else if (dec_mode == MODE_UPPER) begin
          ext_imm = {bus.in_imm, {EXT_W{1'b0}}};
        end
`endif
      end
    end
  endgenerate

  assign bus.in_ready  = !rst && (state != TWO);
  assign bus.out_valid = (state != EMPTY);
  assign bus.out_imm   = (state != EMPTY) ? head_imm  : '0;
  assign bus.out_mode  = (state != EMPTY) ? head_mode : '0;
  assign bus.out_tag   = (state != EMPTY) ? head_tag  : '0;

  assign push = bus.in_valid && bus.in_ready;
  assign pop  = bus.out_valid && bus.out_ready;

  // Skid buffer: head is always the oldest entry; flush beats push/pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= EMPTY;
      head_imm  <= '0;
      head_mode <= '0;
      head_tag  <= '0;
      tail_imm  <= '0;
      tail_mode <= '0;
      tail_tag  <= '0;
    end else if (flush) begin
      state <= EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (push) begin
            head_imm  <= ext_imm;
            head_mode <= dec_mode;
            head_tag  <= bus.in_tag;
            state     <= ONE;
          end
        end
        ONE: begin
          if (push && pop) begin
            head_imm  <= ext_imm;
            head_mode <= dec_mode;
            head_tag  <= bus.in_tag;
          end else if (push) begin
            tail_imm  <= ext_imm;
            tail_mode <= dec_mode;
            tail_tag  <= bus.in_tag;
            state     <= TWO;
          end else if (pop) begin
            state <= EMPTY;
          end
        end
        TWO: begin
          if (pop) begin
            head_imm  <= tail_imm;
            head_mode <= tail_mode;
            head_tag  <= tail_tag;
            state     <= ONE;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_imm_ext_unit.sv
// Self-checking bench for imm_ext_unit. A negedge monitor keeps a queue of
// expected entries (pushed when an offer is accepted, popped when the head
// is consumed) and checks the handshake and head fields every cycle; the
// directed sequence below adds point checks for latency, backpressure,
// flush and asynchronous reset.
module tb_imm_ext_unit;

  localparam int IMM_W  = 16;
  localparam int DATA_W = 32;
  localparam int TAG_W  = 5;

  typedef struct packed {
    logic [DATA_W-1:0] imm;
    logic [1:0]        mode;
    logic [TAG_W-1:0]  tag;
  } entry_t;

  logic clk   = 1'b0;
  logic rst   = 1'b0;
  logic flush = 1'b0;

  int compared   = 0;
  int mismatched = 0;

  entry_t sb[$];

  imm_ext_unit_if #(.IMM_W(IMM_W), .DATA_W(DATA_W), .TAG_W(TAG_W)) bus ();

  imm_ext_unit #(.IMM_W(IMM_W), .DATA_W(DATA_W), .TAG_W(TAG_W)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus.slave)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  // Reference extension model.
  function automatic entry_t modelEntry(input logic [5:0] op, input logic [IMM_W-1:0] imm,
                                        input logic [TAG_W-1:0] tag);
    entry_t e;
    e.tag = tag;
    if (op == 6'h0c || op == 6'h0d || op == 6'h0e || op == 6'h24 || op == 6'h25) begin
      e.mode = 2'd1;
      e.imm  = {16'h0000, imm};
    end
`ifdef IMM_EXT_UPPER_EN
    else if (op == 6'h0f) begin
      e.mode = 2'd2;
      e.imm  = {imm, 16'h0000};
    end
`endif
    else begin
      e.mode = 2'd0;
      e.imm  = {{16{imm[15]}}, imm};
    end
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", name, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [5:0] op,
                               input logic [IMM_W-1:0] imm, input logic [TAG_W-1:0] tag);
    bus.in_valid  = valid;
    bus.in_opcode = op;
    bus.in_imm    = imm;
    bus.in_tag    = tag;
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: compare against the model, then apply the
  // handshakes that the coming rising edge will perform.
  always @(negedge clk) begin
    bit doPush;
    bit doPop;
    if (rst) begin
      sb.delete();
      checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
      checkOutput("rst_in_ready", 32'(bus.in_ready), 32'd0);
      checkOutput("rst_out_imm", bus.out_imm, 32'd0);
    end else begin
      checkOutput("mon_out_valid", 32'(bus.out_valid), 32'(sb.size() != 0));
      checkOutput("mon_in_ready", 32'(bus.in_ready), 32'(sb.size() < 2));
      if (sb.size() != 0) begin
        checkOutput("mon_out_imm", bus.out_imm, sb[0].imm);
        checkOutput("mon_out_mode", 32'(bus.out_mode), 32'(sb[0].mode));
        checkOutput("mon_out_tag", 32'(bus.out_tag), 32'(sb[0].tag));
      end else begin
        checkOutput("mon_empty_imm", bus.out_imm, 32'd0);
        checkOutput("mon_empty_mode", 32'(bus.out_mode), 32'd0);
        checkOutput("mon_empty_tag", 32'(bus.out_tag), 32'd0);
      end
      if (flush) begin
        sb.delete();
      end else begin
        doPop  = (sb.size() != 0) && bus.out_ready;
        doPush = bus.in_valid && (sb.size() < 2);
        if (doPop) void'(sb.pop_front());
        if (doPush) sb.push_back(modelEntry(bus.in_opcode, bus.in_imm, bus.in_tag));
      end
    end
  end

  // Safety net so the run always ends.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired before the sequence completed");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [5:0]       zeroOps [5];
    logic [5:0]       rOp;
    logic [IMM_W-1:0] rImm;
    logic [TAG_W-1:0] rTag;
    zeroOps = '{6'h0c, 6'h0d, 6'h0e, 6'h24, 6'h25};

    applyStimulus(1'b0, 6'h00, '0, '0);
    bus.out_ready = 1'b0;

    // Reset from a known low level so the rising edge is seen.
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_in_ready", 32'(bus.in_ready), 32'd0);
    checkOutput("reset_out_valid", 32'(bus.out_valid), 32'd0);
    rst = 1'b0;
    #1;
    checkOutput("release_in_ready", 32'(bus.in_ready), 32'd1);

    // Sign extension, one-cycle latency.
    bus.out_ready = 1'b1;
    applyStimulus(1'b1, 6'h08, 16'h8001, 5'd3);
    stepCycle();
    applyStimulus(1'b0, 6'h00, '0, '0);
    @(negedge clk);
    checkOutput("sign_valid", 32'(bus.out_valid), 32'd1);
    checkOutput("sign_imm", bus.out_imm, 32'hFFFF8001);
    checkOutput("sign_mode", 32'(bus.out_mode), 32'd0);
    checkOutput("sign_tag", 32'(bus.out_tag), 32'd3);
    stepCycle();

    // Zero extension for every logical-immediate opcode.
    foreach (zeroOps[i]) begin
      applyStimulus(1'b1, zeroOps[i], 16'h8001, 5'(i + 4));
      stepCycle();
      applyStimulus(1'b0, 6'h00, '0, '0);
      @(negedge clk);
      checkOutput("zero_imm", bus.out_imm, 32'h00008001);
      checkOutput("zero_mode", 32'(bus.out_mode), 32'd1);
      stepCycle();
    end

    // Opcode 0x0f, with or without the upper path.
    applyStimulus(1'b1, 6'h0f, 16'h1234, 5'd12);
    stepCycle();
    applyStimulus(1'b0, 6'h00, '0, '0);
    @(negedge clk);
`ifdef IMM_EXT_UPPER_EN
    checkOutput("upper_imm", bus.out_imm, 32'h12340000);
    checkOutput("upper_mode", 32'(bus.out_mode), 32'd2);
`else
    checkOutput("upper_imm", bus.out_imm, 32'h00001234);
    checkOutput("upper_mode", 32'(bus.out_mode), 32'd0);
`endif
    stepCycle();

    // Random traffic with random backpressure; the monitor checks it all.
    repeat (60) begin
      rOp  = 6'($urandom());
      rImm = 16'($urandom());
      rTag = 5'($urandom());
      applyStimulus(1'($urandom_range(0, 1)), rOp, rImm, rTag);
      bus.out_ready = 1'($urandom_range(0, 1));
      stepCycle();
    end
    applyStimulus(1'b0, 6'h00, '0, '0);
    bus.out_ready = 1'b1;
    repeat (3) stepCycle();

    // Backpressure: two entries fill the buffer and the head holds.
    bus.out_ready = 1'b0;
    applyStimulus(1'b1, 6'h08, 16'h0001, 5'd1);
    stepCycle();
    applyStimulus(1'b1, 6'h08, 16'h0002, 5'd2);
    stepCycle();
    applyStimulus(1'b1, 6'h08, 16'h0009, 5'd9);
    @(negedge clk);
    checkOutput("bp_in_ready_full", 32'(bus.in_ready), 32'd0);
    checkOutput("bp_head_tag", 32'(bus.out_tag), 32'd1);
    stepCycle();
    @(negedge clk);
    checkOutput("bp_head_hold", 32'(bus.out_tag), 32'd1);
    stepCycle();
    applyStimulus(1'b0, 6'h00, '0, '0);
    bus.out_ready = 1'b1;
    @(negedge clk);
    checkOutput("bp_drain_first", 32'(bus.out_tag), 32'd1);
    stepCycle();
    @(negedge clk);
    checkOutput("bp_drain_second", 32'(bus.out_tag), 32'd2);
    stepCycle();
    @(negedge clk);
    checkOutput("bp_drained", 32'(bus.out_valid), 32'd0);

    // Simultaneous push and pop while holding one entry.
    stepCycle();
    applyStimulus(1'b1, 6'h08, 16'h000a, 5'd10);
    stepCycle();
    applyStimulus(1'b1, 6'h08, 16'h000b, 5'd11);
    @(negedge clk);
    checkOutput("pp_in_ready", 32'(bus.in_ready), 32'd1);
    stepCycle();
    applyStimulus(1'b1, 6'h08, 16'h000c, 5'd12);
    @(negedge clk);
    checkOutput("pp_in_ready2", 32'(bus.in_ready), 32'd1);
    checkOutput("pp_head_tag", 32'(bus.out_tag), 32'd11);
    stepCycle();
    applyStimulus(1'b0, 6'h00, '0, '0);
    @(negedge clk);
    checkOutput("pp_last_tag", 32'(bus.out_tag), 32'd12);
    stepCycle();

    // Flush from the full state with an offer pending.
    bus.out_ready = 1'b0;
    applyStimulus(1'b1, 6'h08, 16'h0014, 5'd20);
    stepCycle();
    applyStimulus(1'b1, 6'h08, 16'h0015, 5'd21);
    stepCycle();
    applyStimulus(1'b1, 6'h08, 16'h0016, 5'd22);
    flush = 1'b1;
    stepCycle();
    flush = 1'b0;
    applyStimulus(1'b0, 6'h00, '0, '0);
    @(negedge clk);
    checkOutput("flush2_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("flush2_in_ready", 32'(bus.in_ready), 32'd1);

    // Flush with one entry: the accepted-looking offer must be dropped.
    stepCycle();
    applyStimulus(1'b1, 6'h08, 16'h0017, 5'd23);
    stepCycle();
    applyStimulus(1'b1, 6'h08, 16'h0018, 5'd24);
    bus.out_ready = 1'b1;
    flush = 1'b1;
    stepCycle();
    flush = 1'b0;
    applyStimulus(1'b0, 6'h00, '0, '0);
    @(negedge clk);
    checkOutput("flush1_out_valid", 32'(bus.out_valid), 32'd0);
    stepCycle();

    // Asynchronous reset with two entries buffered.
    bus.out_ready = 1'b0;
    applyStimulus(1'b1, 6'h08, 16'h001e, 5'd30);
    stepCycle();
    applyStimulus(1'b1, 6'h08, 16'h001f, 5'd31);
    stepCycle();
    applyStimulus(1'b0, 6'h00, '0, '0);
    #1 rst = 1'b1;
    #1;
    checkOutput("arst_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("arst_in_ready", 32'(bus.in_ready), 32'd0);
    checkOutput("arst_out_imm", bus.out_imm, 32'd0);
    checkOutput("arst_out_mode", 32'(bus.out_mode), 32'd0);
    checkOutput("arst_out_tag", 32'(bus.out_tag), 32'd0);
    stepCycle();
    rst = 1'b0;
    bus.out_ready = 1'b1;
    applyStimulus(1'b1, 6'h08, 16'h7abc, 5'd7);
    stepCycle();
    applyStimulus(1'b0, 6'h00, '0, '0);
    @(negedge clk);
    checkOutput("post_rst_imm", bus.out_imm, 32'h00007abc);
    checkOutput("post_rst_tag", 32'(bus.out_tag), 32'd7);
    repeat (3) stepCycle();

    checkOutput("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
